jtag_tap_ctrl: RTL and testbench
================================

// Module: jtag_tap_ctrl
// PURPOSE
//  IEEE 1149.1 TAP controller and instruction decoder that sequences the boundary-scan chain.
//  Contains the 16-state TAP FSM, the instruction register, and the BYPASS and IDCODE data registers.
//  Produces the shift, clock-enable, update and mode controls for every bsr_cell on the chain.
//  Also muxes TDO. Sits between the chip JTAG pins and the boundary-scan register.
// PARAMETERS
//  IR_WIDTH     4             instruction register width (>=2)
//  IDCODE       32'h1000_05FF IDCODE register value; bit0 must be 1
//  OP_EXTEST    4'h0          EXTEST opcode: BSR selected, mode=1
//  OP_SAMPLE    4'h1          SAMPLE/PRELOAD opcode: BSR selected, mode=0
//  OP_IDCODE    4'h2          IDCODE opcode; also the reset instruction
//  (all-ones = BYPASS; any undefined opcode decodes as BYPASS)
// PORTS
//  tck           in   1  JTAG test clock; the only clock
//  reset         in   1  async active-high reset; OR of TRST and POR at top level
//  tms           in   1  test mode select, sampled posedge tck
//  tdi           in   1  test data in; also drives first bsr_cell prevCell
//  tdo           out  1  test data out, updated on negedge tck
//  tdo_en        out  1  high while in SHIFT_DR or SHIFT_IR (negedge-registered)
//  bsr_tdo       in   1  nextCell of the last bsr_cell
//  bsr_shift_dr  out  1  to shiftDR of all cells
//  bsr_clk_en    out  1  enable for the gated clkDR
//  bsr_update_dr out  1  to updateDR of all cells
//  bsr_mode      out  1  to mode of all cells
//  bsr_enable    out  1  to enableIn/enableOut of all cells
//  tap_state     out  4  current FSM state, for debug
// BEHAVIOUR
//  Async reset: state=TEST_LOGIC_RESET, IR=OP_IDCODE, BYPASS=0. All outputs are 0 except tap_state=TLR.
//  FSM advances on posedge tck from tms per 1149.1: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR,
//   EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR.
//   5 consecutive tms=1 reach TLR from any state. TLR with tms=1 holds.
//  TLR (entered synchronously): IR loads OP_IDCODE at the next negedge.
//  IR shift register (posedge):
//   CAP_IR loads {0..0,2'b01}.
//   SH_IR shifts tdi into the MSB, LSB first out.
//   IR latches on negedge in UPD_IR only; it holds through all DR ops.
//  BYPASS (1 bit): CAP_DR loads 0; SH_DR loads tdi.
//  IDCODE shift reg: CAP_DR loads IDCODE; SH_DR shifts right with tdi into bit31.
//  Selected DR output: EXTEST/SAMPLE -> bsr_tdo; IDCODE -> idcode[0]; else -> bypass.
//  All control outputs are registered on negedge tck from the current state and IR.
//   Each output is therefore stable across the whole following high phase.
//  Controls:
//   bsr_shift_dr = (state==SH_DR)&bsr_sel.
//   bsr_clk_en = (state in {CAP_DR,SH_DR})&bsr_sel; the integration ICG forms clkDR.
//   bsr_update_dr = (state==UPD_DR)&bsr_sel. It is high for exactly one tck period, low->high at the negedge.
//   bsr_mode = (IR==OP_EXTEST).
//   bsr_enable = (state!=TLR).
//  tdo = IR[0] in SH_IR, selected DR output in SH_DR, else 0. tdo_en follows the same SH_* gating.
//  IR change at UPD_IR negedge and bsr_mode change happen on the same edge; no bsr_update_dr pulse coincides.
//  Reset asserted mid-shift: all shift contents are discarded, outputs drop to 0 immediately (async).
//  Reset release is synchronised by the top level; first tms sample on the following posedge.
// STRUCTURE
//  Package jtag_pkg: tap_state_t enum (16 states, 4-bit, 1149.1 encoding order).
//   Also holds the OP_* opcode localparams and IR_CAPTURE pattern.
//  Sub-module jtag_tap_fsm: state register + next-state logic only (tck, reset, tms -> state).
//  This module: IR, BYPASS, IDCODE regs, decode, negedge output register, TDO mux.
// TESTING
//  1. Reset, then tms=1 x5 -> tap_state=TLR, IR=OP_IDCODE, all bsr_* outputs 0.
//  2. Shift IDCODE: TLR->SH_DR, 32 tck -> tdo streams 32'h1000_05FF LSB first; first bit=1.
//  3. Load IR=4'hF via SH_IR, then shift DR 1,0,1,1 -> tdo is 0 (bypass capture), then 1,0,1 (one-cycle delay).
//  4. Load EXTEST. Pass CAP_DR, 8xSH_DR, UPD_DR:
//     - bsr_mode=1; bsr_clk_en high 9 tck (1 capture + 8 shift); bsr_shift_dr high 8 tck.
//     - bsr_update_dr pulses exactly 1 tck; tdo mirrors bsr_tdo.
//  5. Load SAMPLE, enter PAUSE_DR mid-shift, resume -> no bsr_clk_en in PAUSE/EX1/EX2; shift continues correctly.
//  6. Assert reset during SH_IR with partial IR -> outputs 0 at once; IR=OP_IDCODE; tdo_en=0.

Source files
------------

// File: rtl/jtag_pkg.sv
// ----------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TAP controller:
//   tap_state_t  - 16 TAP states, 4-bit, in 1149.1 encoding order
//   OP_*         - default instruction opcodes (4-bit)
//   IR_CAPTURE   - low bits loaded into the IR shift register in CAPTURE_IR
// ----------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_t;

    localparam logic [3:0] OP_EXTEST = 4'h0;
    localparam logic [3:0] OP_SAMPLE = 4'h1;
    localparam logic [3:0] OP_IDCODE = 4'h2;
    localparam logic [3:0] OP_BYPASS = 4'hF;

    // The two mandatory capture bits; upper IR bits capture as zero.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// ----------------------------------------------------------------------------
// jtag_tap_fsm
// 16-state IEEE 1149.1 TAP state machine. State register and next-state
// logic only; all decoding is done by the parent.
// Ports:
//   i_tck    in   test clock, state advances on posedge
//   i_rst    in   async active-high reset, forces TEST_LOGIC_RESET
//   i_tms    in   test mode select
//   o_state  out  current TAP state (registered)
// ----------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_rst,
    input  logic       i_tms,
    output tap_state_t o_state
);

    tap_state_t r_state;
    tap_state_t w_state_next;

    // TAP state register
    always_ff @(posedge i_tck or posedge i_rst) begin
        if (i_rst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // TAP next-state function; five tms=1 cycles reach TLR from anywhere
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TLR:      w_state_next = i_tms ? TLR      : RTI;
            RTI:      w_state_next = i_tms ? SEL_DR   : RTI;
            SEL_DR:   w_state_next = i_tms ? SEL_IR   : CAP_DR;
            CAP_DR:   w_state_next = i_tms ? EX1_DR   : SH_DR;
            SH_DR:    w_state_next = i_tms ? EX1_DR   : SH_DR;
            EX1_DR:   w_state_next = i_tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: w_state_next = i_tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   w_state_next = i_tms ? UPD_DR   : SH_DR;
            UPD_DR:   w_state_next = i_tms ? SEL_DR   : RTI;
            SEL_IR:   w_state_next = i_tms ? TLR      : CAP_IR;
            CAP_IR:   w_state_next = i_tms ? EX1_IR   : SH_IR;
            SH_IR:    w_state_next = i_tms ? EX1_IR   : SH_IR;
            EX1_IR:   w_state_next = i_tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: w_state_next = i_tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   w_state_next = i_tms ? UPD_IR   : SH_IR;
            UPD_IR:   w_state_next = i_tms ? SEL_DR   : RTI;
            default:  w_state_next = TLR;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// ----------------------------------------------------------------------------
// jtag_tap_ctrl
// IEEE 1149.1 TAP controller and instruction decoder driving the
// boundary-scan chain. Holds the instruction register, the BYPASS and IDCODE
// data registers, the negedge-registered chain controls and the TDO mux.
// Ports:
//   tck            in   test clock (only clock)
//   reset          in   async active-high reset (TRST | POR)
//   tms            in   test mode select, sampled on posedge tck
//   tdi            in   test data in
//   tdo            out  test data out, registered on negedge tck
//   tdo_en         out  high while in SHIFT_DR / SHIFT_IR
//   bsr_tdo        in   serial output of the last boundary-scan cell
//   bsr_shift_dr   out  shiftDR to all cells
//   bsr_clk_en     out  enable for the gated clkDR
//   bsr_update_dr  out  updateDR to all cells
//   bsr_mode       out  mode to all cells (EXTEST)
//   bsr_enable     out  enableIn/enableOut to all cells
//   tap_state      out  current TAP state for debug
// ----------------------------------------------------------------------------
module jtag_tap_ctrl #(
    parameter int unsigned          IR_WIDTH  = 4,
    parameter logic [31:0]          IDCODE    = 32'h1000_05FF,
    parameter logic [IR_WIDTH-1:0]  OP_EXTEST = IR_WIDTH'(jtag_pkg::OP_EXTEST),
    parameter logic [IR_WIDTH-1:0]  OP_SAMPLE = IR_WIDTH'(jtag_pkg::OP_SAMPLE),
    parameter logic [IR_WIDTH-1:0]  OP_IDCODE = IR_WIDTH'(jtag_pkg::OP_IDCODE)
) (
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    input  logic       bsr_tdo,
    output logic       bsr_shift_dr,
    output logic       bsr_clk_en,
    output logic       bsr_update_dr,
    output logic       bsr_mode,
    output logic       bsr_enable,
    output logic [3:0] tap_state
);

    import jtag_pkg::*;

    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);

    tap_state_t          w_state;

    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_bypass;
    logic [31:0]         r_idcode;

    logic [IR_WIDTH-1:0] w_ir_next;
    logic                w_bsr_sel;
    logic                w_dr_out;
    logic                w_tdo_next;
    logic                w_tdo_en_next;
    logic                w_shift_next;
    logic                w_clk_en_next;
    logic                w_update_next;
    logic                w_mode_next;
    logic                w_enable_next;

    logic                r_tdo;
    logic                r_tdo_en;
    logic                r_shift;
    logic                r_clk_en;
    logic                r_update;
    logic                r_mode;
    logic                r_enable;

    jtag_tap_fsm u_fsm (
        .i_tck   (tck),
        .i_rst   (reset),
        .i_tms   (tms),
        .o_state (w_state)
    );

    // IR shift register: capture fixed pattern, then shift tdi in at the MSB
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            r_ir_shift <= {IR_WIDTH{1'b0}};
        end else if (w_state == CAP_IR) begin
            r_ir_shift <= IR_CAP_VAL;
        end else if (w_state == SH_IR) begin
            r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        end else begin
            r_ir_shift <= r_ir_shift;
        end
    end

    // BYPASS bit: captures 0, then acts as a one-stage delay of tdi
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            r_bypass <= 1'b0;
        end else if (w_state == CAP_DR) begin
            r_bypass <= 1'b0;
        end else if (w_state == SH_DR) begin
            r_bypass <= tdi;
        end else begin
            r_bypass <= r_bypass;
        end
    end

    // IDCODE shift register: captures the ID, shifts right with tdi at bit 31
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            r_idcode <= 32'h0000_0000;
        end else if (w_state == CAP_DR) begin
            r_idcode <= IDCODE;
        end else if (w_state == SH_DR) begin
            r_idcode <= {tdi, r_idcode[31:1]};
        end else begin
            r_idcode <= r_idcode;
        end
    end

    // Next IR value, instruction decode and next values of all negedge outputs.
    // Decode uses the IR value being latched on this same negedge so that
    // bsr_mode switches together with the IR at UPDATE_IR.
    always_comb begin
        w_ir_next     = r_ir;
        w_bsr_sel     = 1'b0;
        w_dr_out      = r_bypass;
        w_tdo_next    = 1'b0;
        w_tdo_en_next = 1'b0;

        if (w_state == TLR) begin
            w_ir_next = OP_IDCODE;
        end else if (w_state == UPD_IR) begin
            w_ir_next = r_ir_shift;
        end else begin
            w_ir_next = r_ir;
        end

        if ((w_ir_next == OP_EXTEST) || (w_ir_next == OP_SAMPLE)) begin
            w_bsr_sel = 1'b1;
        end else begin
            w_bsr_sel = 1'b0;
        end

        // Undefined opcodes fall through to BYPASS
        if ((r_ir == OP_EXTEST) || (r_ir == OP_SAMPLE)) begin
            w_dr_out = bsr_tdo;
        end else if (r_ir == OP_IDCODE) begin
            w_dr_out = r_idcode[0];
        end else begin
            w_dr_out = r_bypass;
        end

        case (w_state)
            SH_IR: begin
                w_tdo_next    = r_ir_shift[0];
                w_tdo_en_next = 1'b1;
            end
            SH_DR: begin
                w_tdo_next    = w_dr_out;
                w_tdo_en_next = 1'b1;
            end
            default: begin
                w_tdo_next    = 1'b0;
                w_tdo_en_next = 1'b0;
            end
        endcase

        w_shift_next  = (w_state == SH_DR) && w_bsr_sel;
        w_clk_en_next = ((w_state == CAP_DR) || (w_state == SH_DR)) && w_bsr_sel;
        w_update_next = (w_state == UPD_DR) && w_bsr_sel;
        w_mode_next   = (w_ir_next == OP_EXTEST);
        w_enable_next = (w_state != TLR);
    end

    // Instruction register: reloads IDCODE in TLR, latches new opcode in UPD_IR
    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            r_ir <= OP_IDCODE;
        end else begin
            r_ir <= w_ir_next;
        end
    end

    // Negedge output register: every control is stable over the next high phase
    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
            r_shift  <= 1'b0;
            r_clk_en <= 1'b0;
            r_update <= 1'b0;
            r_mode   <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_next;
            r_tdo_en <= w_tdo_en_next;
            r_shift  <= w_shift_next;
            r_clk_en <= w_clk_en_next;
            r_update <= w_update_next;
            r_mode   <= w_mode_next;
            r_enable <= w_enable_next;
        end
    end

    assign tdo           = r_tdo;
    assign tdo_en        = r_tdo_en;
    assign bsr_shift_dr  = r_shift;
    assign bsr_clk_en    = r_clk_en;
    assign bsr_update_dr = r_update;
    assign bsr_mode      = r_mode;
    assign bsr_enable    = r_enable;
    assign tap_state     = w_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jtag_tap_ctrl
// Directed bench for jtag_tap_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1 ns after the falling edge, when both the
// posedge state and the negedge-registered controls have settled.
// ----------------------------------------------------------------------------
module tb_jtag_tap_ctrl;

    localparam logic [3:0] S_TLR    = 4'd0;
    localparam logic [3:0] S_RTI    = 4'd1;
    localparam logic [3:0] S_CAP_DR = 4'd3;
    localparam logic [3:0] S_SH_DR  = 4'd4;
    localparam logic [3:0] S_CAP_IR = 4'd10;
    localparam logic [3:0] S_SH_IR  = 4'd11;
    localparam logic [3:0] S_UPD_IR = 4'd15;

    logic       tck;
    logic       reset;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       bsr_tdo;
    logic       bsr_shift_dr;
    logic       bsr_clk_en;
    logic       bsr_update_dr;
    logic       bsr_mode;
    logic       bsr_enable;
    logic [3:0] tap_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cap32;
    logic [7:0]  cap8;
    logic [3:0]  cap4;
    logic [7:0]  pat8;
    int          clk_cnt;
    int          sh_cnt;
    int          upd_cnt;

    // Test 5 walk: SEL,CAP,SH,SH,EX1,PAUSE,PAUSE,EX2,SH,SH,EX1,UPD,RTI
    logic       t5_tms [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] t5_st  [13] = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd6,
                                4'd7, 4'd4, 4'd4, 4'd5, 4'd8, 4'd1};
    logic       t5_ce  [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       t5_sh  [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    jtag_tap_ctrl dut (
        .tck           (tck),
        .reset         (reset),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_en        (tdo_en),
        .bsr_tdo       (bsr_tdo),
        .bsr_shift_dr  (bsr_shift_dr),
        .bsr_clk_en    (bsr_clk_en),
        .bsr_update_dr (bsr_update_dr),
        .bsr_mode      (bsr_mode),
        .bsr_enable    (bsr_enable),
        .tap_state     (tap_state)
    );

    // Test clock, 10 ns period
    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One tck cycle: drive, cross posedge and negedge, settle
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RTI: load an opcode through the IR path and return to RTI
    task automatic load_ir(input logic [3:0] val, input logic exp_mode);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("ir_sh_state", {28'd0, tap_state}, {28'd0, S_SH_IR});
        check_val("ir_cap_tdo", {31'd0, tdo}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step((i == 3), val[i]);
        end
        step(1'b1, 1'b0);
        check_val("upd_ir_state", {28'd0, tap_state}, {28'd0, S_UPD_IR});
        check_val("upd_ir_mode", {31'd0, bsr_mode}, {31'd0, exp_mode});
        check_val("upd_ir_no_upd_dr", {31'd0, bsr_update_dr}, 32'd0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        tms     = 1'b1;
        tdi     = 1'b0;
        bsr_tdo = 1'b0;
        @(negedge tck);
        #1;

        // ---- 1. reset state and five-ones return to TLR ----
        check_val("rst_state", {28'd0, tap_state}, {28'd0, S_TLR});
        check_val("rst_outs", {25'd0, tdo, tdo_en, bsr_shift_dr, bsr_clk_en,
                  bsr_update_dr, bsr_mode, bsr_enable}, 32'd0);
        reset = 1'b0;
        step(1'b0, 1'b0);
        check_val("rti_state", {28'd0, tap_state}, {28'd0, S_RTI});
        check_val("rti_enable", {31'd0, bsr_enable}, 32'd1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_val("cap_ir_state", {28'd0, tap_state}, {28'd0, S_CAP_IR});
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
        end
        check_val("tlr_5ones", {28'd0, tap_state}, {28'd0, S_TLR});
        check_val("tlr_bsr_outs", {27'd0, bsr_shift_dr, bsr_clk_en,
                  bsr_update_dr, bsr_mode, bsr_enable}, 32'd0);
        step(1'b1, 1'b0);
        check_val("tlr_hold", {28'd0, tap_state}, {28'd0, S_TLR});

        // ---- 2. shift IDCODE out ----
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("id_sh_state", {28'd0, tap_state}, {28'd0, S_SH_DR});
        check_val("id_tdo_en", {31'd0, tdo_en}, 32'd1);
        check_val("id_first_bit", {31'd0, tdo}, 32'd1);
        cap32[0] = tdo;
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b0);
            cap32[i] = tdo;
        end
        check_val("idcode", cap32, 32'h1000_05FF);
        step(1'b1, 1'b0);
        check_val("ex1_tdo_en", {31'd0, tdo_en}, 32'd0);
        step(1'b1, 1'b0);
        check_val("id_no_upd", {31'd0, bsr_update_dr}, 32'd0);
        step(1'b0, 1'b0);

        // ---- 3. BYPASS: one-cycle delay after a 0 capture ----
        load_ir(4'hF, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cap4[0] = tdo;
        step(1'b0, 1'b1);
        cap4[1] = tdo;
        step(1'b0, 1'b0);
        cap4[2] = tdo;
        step(1'b0, 1'b1);
        cap4[3] = tdo;
        check_val("bypass_tdo", {28'd0, cap4}, {28'd0, 4'b1010});
        check_val("bypass_bsr_quiet", {29'd0, bsr_shift_dr, bsr_clk_en, bsr_mode}, 32'd0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // ---- 4. EXTEST: capture + 8 shifts + update ----
        load_ir(4'h0, 1'b1);
        pat8    = 8'hA5;
        clk_cnt = 0;
        sh_cnt  = 0;
        upd_cnt = 0;
        cap8    = 8'h00;
        for (int s = 0; s < 13; s++) begin
            bsr_tdo = ((s >= 2) && (s <= 9)) ? pat8[s-2] : 1'b0;
            step(((s == 0) || (s == 10) || (s == 11)), 1'b0);
            clk_cnt += int'(bsr_clk_en);
            sh_cnt  += int'(bsr_shift_dr);
            upd_cnt += int'(bsr_update_dr);
            if ((s >= 2) && (s <= 9)) begin
                cap8[s-2] = tdo;
            end
            if (s == 1) begin
                check_val("ext_cap_state", {28'd0, tap_state}, {28'd0, S_CAP_DR});
            end
            if (s == 11) begin
                check_val("ext_upd_pulse", {31'd0, bsr_update_dr}, 32'd1);
            end
        end
        check_val("ext_clk_en_cnt", clk_cnt, 32'd9);
        check_val("ext_shift_cnt", sh_cnt, 32'd8);
        check_val("ext_upd_cnt", upd_cnt, 32'd1);
        check_val("ext_tdo_mirror", {24'd0, cap8}, {24'd0, pat8});
        check_val("ext_mode", {31'd0, bsr_mode}, 32'd1);

        // ---- 5. SAMPLE with a pause in the middle of the shift ----
        load_ir(4'h1, 1'b0);
        sh_cnt = 0;
        for (int s = 0; s < 13; s++) begin
            bsr_tdo = s[0];
            step(t5_tms[s], 1'b0);
            check_val("smp_state", {28'd0, tap_state}, {28'd0, t5_st[s]});
            check_val("smp_clk_en", {31'd0, bsr_clk_en}, {31'd0, t5_ce[s]});
            sh_cnt += int'(bsr_shift_dr);
            if (t5_sh[s]) begin
                check_val("smp_tdo_mirror", {31'd0, tdo}, {31'd0, bsr_tdo});
            end
        end
        check_val("smp_shift_cnt", sh_cnt, 32'd4);
        check_val("smp_mode", {31'd0, bsr_mode}, 32'd0);

        // ---- 6. reset in the middle of an IR shift ----
        load_ir(4'h0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check_val("pre_rst_tdo_en", {31'd0, tdo_en}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_state", {28'd0, tap_state}, {28'd0, S_TLR});
        check_val("mid_rst_outs", {25'd0, tdo, tdo_en, bsr_shift_dr, bsr_clk_en,
                  bsr_update_dr, bsr_mode, bsr_enable}, 32'd0);
        @(negedge tck);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cap8[0] = tdo;
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b0);
            cap8[i] = tdo;
        end
        check_val("post_rst_idcode_lo", {24'd0, cap8}, 32'h0000_00FF);
        check_val("post_rst_mode", {31'd0, bsr_mode}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
